// File: rtl/bf_pipe_if.sv
// rtl/bf_pipe_if.sv - sample/result bundle for one NTT butterfly lane
interface bf_pipe_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] w;
  logic         out_valid;
  logic [W-1:0] o1;
  logic [W-1:0] o2;

  modport master (
    output in_valid, mode, i1, i2, w,
    input  out_valid, o1, o2
  );

  modport slave (
    input  in_valid, mode, i1, i2, w,
    output out_valid, o1, o2
  );
endinterface

// File: rtl/bf_pipe.sv
// rtl/bf_pipe.sv - pipelined modular butterfly (CT / GS / GS_HALF / MUL per sample)
module bf_pipe #(
  parameter int W       = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  bf_pipe_if.slave   bus
);
  localparam int LAT = MUL_LAT + 3;

  localparam logic [1:0] MD_CT  = 2'd0;
  localparam logic [1:0] MD_GS  = 2'd1;
  localparam logic [1:0] MD_GSH = 2'd2;

  localparam logic [W:0]   QW = (W+1)'(Q);
  // Barrett constant floor(2^(2W)/Q); estimate is at most 2 below the true quotient
  localparam logic [2*W:0] BM = {1'b1, {(2*W){1'b0}}} / (2*W+1)'(Q);

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QW) s = s - QW;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + QW - {1'b0, b};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + QW) : {1'b0, x};
    return t[W:1];
  endfunction

  function automatic logic [W-1:0] mod_red(input logic [2*W-1:0] p);
    logic [4*W:0] t;
    logic [W+1:0] r;
    t = ((4*W+1)'(p) * (4*W+1)'(BM)) >> (2*W);
    r = (W+2)'((4*W+1)'(p) - t * (4*W+1)'(Q));
    if (r >= (W+2)'(Q)) r = r - (W+2)'(Q);
    if (r >= (W+2)'(Q)) r = r - (W+2)'(Q);
    return r[W-1:0];
  endfunction

  logic [LAT-1:0]   vpipe;
  logic [1:0]       s0_mode, s1_mode;
  logic [W-1:0]     s0_a, s0_b, s0_w;
  logic [W-1:0]     s1_x, s1_y, s1_w;
  logic [W-1:0]     pre_x, pre_y, pre_sum, pre_dif;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     xd [MUL_LAT];
  logic [1:0]       md [MUL_LAT];
  logic [W-1:0]     mout;
  logic [W-1:0]     post_1, post_2;
  logic [W-1:0]     o1_q, o2_q;

  always_comb begin
    pre_sum = add_mod(s0_a, s0_b);
    pre_dif = sub_mod(s0_b, s0_a);
    pre_x   = s0_a;
    pre_y   = s0_b;
    case (s0_mode)
      MD_GS: begin
        pre_x = pre_sum;
        pre_y = pre_dif;
      end
      MD_GSH: begin
        pre_x = half_mod(pre_sum);
        pre_y = half_mod(pre_dif);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe   <= '0;
      s0_mode <= '0;
      s0_a    <= '0;
      s0_b    <= '0;
      s0_w    <= '0;
      s1_mode <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_w    <= '0;
      prod    <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        xd[i] <= '0;
        md[i] <= '0;
      end
      o1_q    <= '0;
      o2_q    <= '0;
    end else if (en) begin
      vpipe   <= {vpipe[LAT-2:0], bus.in_valid};
      s0_mode <= bus.mode;
      s0_a    <= bus.i1;
      s0_b    <= bus.i2;
      s0_w    <= bus.w;
      s1_mode <= s0_mode;
      s1_x    <= pre_x;
      s1_y    <= pre_y;
      s1_w    <= s0_w;
      prod    <= {{W{1'b0}}, s1_y} * {{W{1'b0}}, s1_w};
      xd[0]   <= s1_x;
      md[0]   <= s1_mode;
      for (int i = 1; i < MUL_LAT; i++) begin
        xd[i] <= xd[i-1];
        md[i] <= md[i-1];
      end
      // bubbles leave the last valid result on o1/o2
      if (vpipe[LAT-2]) begin
        o1_q <= post_1;
        o2_q <= post_2;
      end
    end
  end

  // Multiplier: stage 0 holds the raw product, later stages hold the reduced value
  if (MUL_LAT == 1) begin : g_mul1
    assign mout = mod_red(prod);
  end else begin : g_muln
    logic [W-1:0] rd [MUL_LAT-1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < MUL_LAT-1; i++) rd[i] <= '0;
      end else if (en) begin
        rd[0] <= mod_red(prod);
        for (int i = 1; i < MUL_LAT-1; i++) rd[i] <= rd[i-1];
      end
    end
    assign mout = rd[MUL_LAT-2];
  end

  always_comb begin
    post_1 = xd[MUL_LAT-1];
    post_2 = mout;
    if (md[MUL_LAT-1] == MD_CT) begin
      post_1 = add_mod(xd[MUL_LAT-1], mout);
      post_2 = sub_mod(xd[MUL_LAT-1], mout);
    end
  end

  assign bus.out_valid = vpipe[LAT-1];
  assign bus.o1        = o1_q;
  assign bus.o2        = o2_q;
endmodule
